// File: rtl/data_check_pkg.sv
// Shared types and helpers for the lane-based receive pattern checker.
package data_check_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic int unsigned lanes_of(input int unsigned data_w, input int unsigned lane_w);
        return data_w / lane_w;
    endfunction

    // Counters up to 64 bits wide; callers zero-extend in and truncate back out.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/data_check_lanes_lane_cmp.sv
// Single-lane comparator: flags a lane whose value is not prev + DATA_INTERVAL (mod 2^LANE_W).
module lane_cmp #(
    parameter int LANE_W        = 64,
    parameter int DATA_INTERVAL = 2
) (
    input  logic [LANE_W-1:0] prev_i,
    input  logic [LANE_W-1:0] cur_i,
    output logic              mis_o
);

    localparam logic [LANE_W-1:0] STEP = LANE_W'(DATA_INTERVAL);

    logic [LANE_W-1:0] expected;

    always_comb begin
        expected = prev_i + STEP;
        mis_o    = (cur_i != expected);
    end

endmodule

// File: rtl/data_check_lanes.sv
// Receive-side incrementing-pattern checker: per-lane compare, lock/loss FSM,
// saturating error/word counters and first-error capture.
module data_check_lanes
    import data_check_pkg::*;
#(
    parameter int DATA_W        = 128,
    parameter int LANE_W        = 64,
    parameter int DATA_INTERVAL = 2,
    parameter int LOCK_CNT      = 4,
    parameter int LOSS_CNT      = 4,
    parameter int CNT_W         = 32,
    localparam int LANES        = lanes_of(DATA_W, LANE_W)
) (
    input  logic              clk_usr,
    input  logic              rst,
    input  logic [DATA_W-1:0] usr_rx,
    input  logic              usr_rx_valid,
    input  logic              clr,
    output logic              locked,
    output logic              err,
    output logic [LANES-1:0]  err_lane,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              first_err_valid,
    output logic [DATA_W-1:0] first_err_data
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);

    logic [DATA_W-1:0] rx_q, prev_q;
    logic              rx_vld_q, have_prev_q;

    state_e            state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [MISS_W-1:0] miss_q, miss_d;

    logic [LANES-1:0]  mis;
    logic              any_mis, cmp, err_evt;

    logic              err_q, err_d;
    logic [LANES-1:0]  err_lane_q, err_lane_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              fev_q, fev_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_cmp #(
            .LANE_W       (LANE_W),
            .DATA_INTERVAL(DATA_INTERVAL)
        ) u_lane_cmp (
            .prev_i(prev_q[g*LANE_W +: LANE_W]),
            .cur_i (rx_q[g*LANE_W +: LANE_W]),
            .mis_o (mis[g])
        );
    end

    assign any_mis = |mis;
    assign cmp     = rx_vld_q & have_prev_q;

    always_ff @(posedge clk_usr or posedge rst) begin
        if (rst) begin
            rx_q        <= '0;
            rx_vld_q    <= 1'b0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else begin
            rx_q     <= usr_rx;
            rx_vld_q <= usr_rx_valid;
            if (rx_vld_q) begin
                prev_q      <= rx_q;
                have_prev_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_usr or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
            run_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        miss_d  = miss_q;
        if (cmp) begin
            case (state_q)
                SEARCH: begin
                    if (any_mis) begin
                        run_d = '0;
                    end else if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        run_d   = '0;
                        miss_d  = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!any_mis) begin
                        miss_d = '0;
                    end else if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
                        state_d = SEARCH;
                        run_d   = '0;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // Clear restarts each counter from this cycle's own increment rather than dropping it.
    always_comb begin
        locked     = (state_q == LOCKED);
        err_evt    = cmp & any_mis & (state_q == LOCKED);
        err_d      = err_evt;
        err_lane_d = err_evt ? mis : '0;
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        fev_d      = fev_q;
        fdata_d    = fdata_q;
        if (clr) begin
            word_cnt_d = CNT_W'(cmp);
            err_cnt_d  = CNT_W'(err_evt);
            fev_d      = err_evt;
            fdata_d    = err_evt ? rx_q : '0;
        end else begin
            if (cmp)
                word_cnt_d = CNT_W'(sat_inc(64'(word_cnt_q), CNT_W));
            if (err_evt)
                err_cnt_d = CNT_W'(sat_inc(64'(err_cnt_q), CNT_W));
            if (err_evt && !fev_q) begin
                fev_d   = 1'b1;
                fdata_d = rx_q;
            end
        end
    end

    always_ff @(posedge clk_usr or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_lane_q <= '0;
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
            fev_q      <= 1'b0;
            fdata_q    <= '0;
        end else begin
            err_q      <= err_d;
            err_lane_q <= err_lane_d;
            err_cnt_q  <= err_cnt_d;
            word_cnt_q <= word_cnt_d;
            fev_q      <= fev_d;
            fdata_q    <= fdata_d;
        end
    end

    assign err             = err_q;
    assign err_lane        = err_lane_q;
    assign err_cnt         = err_cnt_q;
    assign word_cnt        = word_cnt_q;
    assign first_err_valid = fev_q;
    assign first_err_data  = fdata_q;

endmodule

// File: tb/tb_data_check_lanes.sv
// Bench for data_check_lanes: two instances (32-bit and 4-bit counters) share one
// stimulus stream and are compared every cycle against a word-level reference model.
module tb_data_check_lanes;

    logic         clk_usr = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] usr_rx = '0;
    logic         usr_rx_valid = 1'b0;
    logic         clr = 1'b0;

    logic         a_locked, a_err, a_fv;
    logic [1:0]   a_lane;
    logic [31:0]  a_ecnt, a_wcnt;
    logic [127:0] a_fd;
    logic         b_locked, b_err, b_fv;
    logic [1:0]   b_lane;
    logic [3:0]   b_ecnt, b_wcnt;
    logic [127:0] b_fd;

    data_check_lanes u_dut_a (
        .clk_usr(clk_usr), .rst(rst), .usr_rx(usr_rx), .usr_rx_valid(usr_rx_valid), .clr(clr),
        .locked(a_locked), .err(a_err), .err_lane(a_lane), .err_cnt(a_ecnt), .word_cnt(a_wcnt),
        .first_err_valid(a_fv), .first_err_data(a_fd)
    );

    data_check_lanes #(.CNT_W(4)) u_dut_b (
        .clk_usr(clk_usr), .rst(rst), .usr_rx(usr_rx), .usr_rx_valid(usr_rx_valid), .clr(clr),
        .locked(b_locked), .err(b_err), .err_lane(b_lane), .err_cnt(b_ecnt), .word_cnt(b_wcnt),
        .first_err_valid(b_fv), .first_err_data(b_fd)
    );

    always #5 clk_usr = ~clk_usr;

    int checks = 0;
    int errors = 0;

    // Reference model state: lanes as 64-bit integers, counts as plain integers.
    logic [63:0]  m_prev [2];
    bit           m_have, m_locked, m_err, m_fv;
    int unsigned  m_run, m_miss, m_words, m_errs;
    logic [1:0]   m_lane;
    logic [127:0] m_fd;
    logic [127:0] p_d;
    bit           p_v;

    logic [63:0]  cur [2];
    bit           err_seen;

    function automatic logic [3:0] sat4(input int unsigned v);
        return (v > 15) ? 4'hF : v[3:0];
    endfunction

    function automatic void m_reset();
        m_prev[0] = '0; m_prev[1] = '0;
        m_have = 0; m_locked = 0; m_err = 0; m_fv = 0;
        m_run = 0; m_miss = 0; m_words = 0; m_errs = 0;
        m_lane = '0; m_fd = '0; p_d = '0; p_v = 0;
    endfunction

    function automatic void m_word(input logic [127:0] w, input bit v, input bit c);
        logic [1:0]  bad;
        logic [63:0] ln;
        m_err = 0; m_lane = '0;
        if (c) begin m_words = 0; m_errs = 0; m_fv = 0; m_fd = '0; end
        if (v) begin
            for (int i = 0; i < 2; i++) begin
                ln = w[i*64 +: 64];
                bad[i] = (ln != m_prev[i] + 64'd2);
            end
            if (m_have) begin
                m_words++;
                if (m_locked) begin
                    if (bad != 0) begin
                        m_err = 1; m_lane = bad; m_errs++; m_miss++;
                        if (!m_fv) begin m_fv = 1; m_fd = w; end
                        if (m_miss == 4) begin m_locked = 0; m_run = 0; end
                    end else m_miss = 0;
                end else if (bad == 0) begin
                    m_run++;
                    if (m_run == 4) begin m_locked = 1; m_run = 0; m_miss = 0; end
                end else m_run = 0;
            end
            for (int i = 0; i < 2; i++) m_prev[i] = w[i*64 +: 64];
            m_have = 1;
        end
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a.locked", 128'(a_locked), 128'(m_locked));
        chk("a.err",    128'(a_err),    128'(m_err));
        chk("a.lane",   128'(a_lane),   128'(m_lane));
        chk("a.errcnt", 128'(a_ecnt),   128'(m_errs));
        chk("a.wcnt",   128'(a_wcnt),   128'(m_words));
        chk("a.fv",     128'(a_fv),     128'(m_fv));
        chk("a.fdata",  a_fd,           m_fd);
        chk("b.locked", 128'(b_locked), 128'(m_locked));
        chk("b.err",    128'(b_err),    128'(m_err));
        chk("b.lane",   128'(b_lane),   128'(m_lane));
        chk("b.errcnt", 128'(b_ecnt),   128'(sat4(m_errs)));
        chk("b.wcnt",   128'(b_wcnt),   128'(sat4(m_words)));
        chk("b.fv",     128'(b_fv),     128'(m_fv));
        chk("b.fdata",  b_fd,           m_fd);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".a"}, {a_fd[127:72], a_locked, a_err, a_lane, a_ecnt, a_wcnt, a_fv, 1'b0}, '0);
        chk({tag, ".afd"}, a_fd, '0);
        chk({tag, ".b"}, 128'({b_locked, b_err, b_lane, b_ecnt, b_wcnt, b_fv}), '0);
        chk({tag, ".bfd"}, b_fd, '0);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input logic [127:0] d, input bit v, input bit c);
        usr_rx = d; usr_rx_valid = v; clr = c;
        @(posedge clk_usr);
        m_word(p_d, p_v, c);
        p_d = d; p_v = v;
        #1;
        check_all();
        if (a_err || b_err) err_seen = 1;
    endtask

    function automatic logic [127:0] good_word();
        return {cur[1], cur[0]};
    endfunction

    task automatic send_good(input bit c);
        step(good_word(), 1, c);
        cur[0] += 64'd2; cur[1] += 64'd2;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] corrupt(input logic [127:0] w, input int lane);
        logic [63:0] r;
        r = {$urandom, $urandom} | 64'd1;
        return (lane == 1) ? (w ^ {r, 64'd0}) : (w ^ {64'd0, r});
    endfunction

    initial begin
        logic [127:0] cw;
        int           lock_step, nvalid, guard;

        // Reset state
        m_reset();
        #1 rst = 1'b1;
        #2 check_zero("reset");
        @(posedge clk_usr); @(posedge clk_usr);
        @(negedge clk_usr) rst = 1'b0;

        // Lock and clean run: lanes 0x10/0x20, +2 per word, 20 words back to back
        cur[0] = 64'h10; cur[1] = 64'h20;
        err_seen = 0; lock_step = 0;
        for (int k = 1; k <= 20; k++) begin
            send_good(0);
            if (a_locked && lock_step == 0) lock_step = k;
        end
        step('0, 0, 0); step('0, 0, 0);
        chk("clean.lock_step", 128'(lock_step), 128'(6));
        chk("clean.wcnt", 128'(a_wcnt), 128'(19));
        chk("clean.errcnt", 128'(a_ecnt), 128'(0));
        chk("clean.no_err", 128'(err_seen), 128'(0));

        // Single-lane error in lane 1
        cw = corrupt(good_word(), 1);
        step(cw, 1, 0); cur[0] += 64'd2; cur[1] += 64'd2;
        send_good(0);
        chk("single.err", 128'(a_err), 128'(1));
        chk("single.lane", 128'(a_lane), 128'(2'b10));
        chk("single.errcnt", 128'(a_ecnt), 128'(1));
        chk("single.fdata", a_fd, cw);
        send_good(0);
        chk("single.errcnt2", 128'(a_ecnt), 128'(2));
        chk("single.lane2", 128'(a_lane), 128'(2'b10));
        for (int k = 0; k < 3; k++) send_good(0);
        chk("single.locked", 128'(a_locked), 128'(1));

        // Loss after 4 consecutive bad words, then relock
        for (int k = 0; k < 4; k++) step(rnd128(), 1, 0);
        chk("loss.still_locked", 128'(a_locked), 128'(1));
        send_good(0);
        chk("loss.unlocked", 128'(a_locked), 128'(0));
        chk("loss.err_on_last", 128'(a_err), 128'(1));
        for (int k = 0; k < 4; k++) send_good(0);
        chk("relock.not_yet", 128'(a_locked), 128'(0));
        send_good(0);
        chk("relock.locked", 128'(a_locked), 128'(1));

        // Saturation of 4-bit counters, then clear coinciding with an error result
        for (int k = 0; k < 10; k++) begin
            step(corrupt(good_word(), int'($urandom_range(0, 1))), 1, 0);
            cur[0] += 64'd2; cur[1] += 64'd2;
            send_good(0); send_good(0);
        end
        cw = corrupt(good_word(), 0);
        step(cw, 1, 0); cur[0] += 64'd2; cur[1] += 64'd2;
        chk("sat.b_errcnt", 128'(b_ecnt), 128'(4'hF));
        chk("sat.b_wcnt", 128'(b_wcnt), 128'(4'hF));
        send_good(1);
        chk("clr.a_errcnt", 128'(a_ecnt), 128'(1));
        chk("clr.b_errcnt", 128'(b_ecnt), 128'(1));
        chk("clr.a_wcnt", 128'(a_wcnt), 128'(1));
        chk("clr.a_fdata", a_fd, cw);
        chk("clr.b_fdata", b_fd, cw);
        send_good(0);
        chk("clr.errcnt_next", 128'(a_ecnt), 128'(2));
        send_good(0); send_good(0);

        // Reset mid-stream with an error result in flight
        step(corrupt(good_word(), 1), 1, 0); cur[0] += 64'd2; cur[1] += 64'd2;
        #2 rst = 1'b1;
        #1 check_zero("midrst");
        m_reset();
        usr_rx_valid = 1'b0;
        @(posedge clk_usr); @(posedge clk_usr);
        @(negedge clk_usr) rst = 1'b0;

        // Lane 0 wraps through all-ones with random valid gaps
        cur[0] = 64'hFFFF_FFFF_FFFF_FFFA;
        cur[1] = {$urandom, $urandom};
        err_seen = 0; nvalid = 0; guard = 0;
        while (nvalid < 14 && guard < 200) begin
            guard++;
            if ($urandom_range(0, 1) == 1) begin
                send_good(0);
                nvalid++;
            end else begin
                step(rnd128(), 0, 0);
            end
        end
        step('0, 0, 0); step('0, 0, 0);
        chk("wrap.bound", 128'(nvalid), 128'(14));
        chk("wrap.no_err", 128'(err_seen), 128'(0));
        chk("wrap.wcnt", 128'(a_wcnt), 128'(nvalid - 1));
        chk("wrap.locked", 128'(a_locked), 128'(1));
        chk("wrap.errcnt", 128'(a_ecnt), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_check_lanes.md
# data_check_lanes

Parametrised receive-side pattern checker for the PCIe/fibre user data path, sitting after the receive FIFO on `clk_usr`. It splits each received word into independent lanes, each carrying an incrementing counter that advances by `DATA_INTERVAL` per valid word. It checks every lane against the expected value and runs a lock/loss state machine. It maintains saturating error and word counters, captures the first failing word, and raises a per-word error pulse for debug LEDs and ILA triggers.

## Interface
- `DATA_W`, 128: received word width; must be a multiple of `LANE_W`.
- `LANE_W`, 64: lane width; `LANES = DATA_W/LANE_W`.
- `DATA_INTERVAL`, 2: per-word increment per lane, truncated to `LANE_W`.
- `LOCK_CNT`, 4: consecutive all-lane-matching words needed to enter LOCKED (≥1).
- `LOSS_CNT`, 4: consecutive mismatching words in LOCKED that force a return to SEARCH (≥1).
- `CNT_W`, 32: width of the error and word counters.

Ports:
- `clk_usr`: in, 1. User clock.
- `rst`: in, 1. Reset, asynchronous, active-high.
- `usr_rx`: in, `DATA_W`. Received data.
- `usr_rx_valid`: in, 1. `usr_rx` is valid this cycle.
- `clr`: in, 1. Synchronous clear of the counters and the capture registers; does not affect lock state.
- `locked`: out, 1. State is LOCKED.
- `err`: out, 1. One-cycle pulse per mismatching word while LOCKED.
- `err_lane`: out, `LANES`. Per-lane mismatch flags, qualified by `err`; zero otherwise.
- `err_cnt`: out, `CNT_W`. Count of mismatching words while LOCKED; saturating.
- `word_cnt`: out, `CNT_W`. Count of valid words checked; saturating.
- `first_err_valid`: out, 1. `first_err_data` holds a captured word.
- `first_err_data`: out, `DATA_W`. The first mismatching word seen in LOCKED since reset or `clr`.

## Operation
- **Stage 0:** register `usr_rx` and `usr_rx_valid` on every cycle. Compare logic sees only these registered values.
- **Reference:** `prev` is the last valid registered word, qualified by `have_prev` (cleared on reset).
- **Expected value:** per lane, `expected[i] = prev[i] + DATA_INTERVAL`, modulo 2^`LANE_W`. Wrap from all-ones back to a low value is legal and is not an error.
- **Compare:** only when the registered valid is high and `have_prev` is 1. The first valid word after reset only seeds `prev`.
- **Mismatch vector:** `mis[i]` = lane `i` differs from `expected[i]`. `any_mis = |mis`.
- **Reseeding:** `prev` is always reloaded from the received word, so the checker resynchronises after a skip.
- **Invalid cycles:** gaps in `usr_rx_valid` hold `prev`, both run counters and the state. They produce no `err`.
- **FSM SEARCH (reset state):**
  - Match: `run` +1. When `run` reaches `LOCK_CNT`, go to LOCKED and set `run` and `miss` to 0.
  - Mismatch: `run` = 0.
  - Errors are never counted or flagged in SEARCH.
- **FSM LOCKED:**
  - Mismatch: pulse `err`, drive `err_lane = mis`, `err_cnt` +1, `miss` +1.
  - When `miss` reaches `LOSS_CNT`, go to SEARCH with `run` = 0.
  - Match: `miss` = 0.
- **`word_cnt`:** +1 on every compared word, in either state.
- **First-error capture:** on the first LOCKED mismatch with `first_err_valid` = 0, load `first_err_data` with the received word and set `first_err_valid`.
- **Saturation:** both counters stick at all-ones.
- **`clr` priority:** `clr` wins over increments. In a cycle where `clr` and an event coincide, each counter loads 0 plus that cycle's increment (0 or 1), and capture reloads from that word if it errs. FSM, `prev` and `have_prev` are unaffected by `clr`.
- **Reset values:**
  - All outputs are 0 and the state is SEARCH.
  - `have_prev`, `run`, `miss` and `prev` are 0.
  - Reset mid-stream discards lock; the next valid word only reseeds.

## Timing
- Word sampled on `usr_rx` at edge N is registered at N. Its `err`, `err_lane`, counters, capture and state update at edge N+1, so total latency is 2 cycles.
- `locked` rises at the edge that processes the `LOCK_CNT`-th matching word. It falls at the edge that processes the `LOSS_CNT`-th consecutive mismatch; that mismatch still pulses `err`.
- Back-to-back valid words are supported at one word per cycle. No backpressure.

## Structure
- Shared package `data_check_pkg`: the state enum (SEARCH, LOCKED), a `LANES` derivation function and a saturating-increment function.
- One sub-module, `lane_cmp`, instantiated `LANES` times. It takes `prev`, `cur` and `DATA_INTERVAL` and returns `mis`.
- FSM, counters and capture live in the top.

## Test plan
- **Lock and clean run:** with 128/64 defaults, drive lanes starting at 0x10/0x20, +2 per word for 20 words, valid every cycle. `locked` rises on the 5th word's result (seed + 4 matches). `err` is never asserted, `word_cnt` = 19, `err_cnt` = 0.
- **Single-lane error:** once locked, corrupt lane 1 of one word. Exactly one `err` pulse with `err_lane = 2'b10`, `err_cnt` = 1, and `first_err_data` equals the corrupted word. The next word mismatches again, because `prev` was reseeded from the corrupted word, giving `err_cnt` = 2. `locked` stays high.
- **Loss and relock:** once locked, send 4 consecutive bad words. `locked` falls on the 4th. Resume a clean sequence and relock after 4 matches.
- **Wrap and gaps:** lane 0 goes 0xFFFF_FFFF_FFFF_FFFE then 0x0, with random `usr_rx_valid` gaps. No `err`, and `word_cnt` counts valid words only.
- **Saturation and clear:** with `CNT_W` = 4, inject 20 errors. `err_cnt` = 0xF. Assert `clr` in the same cycle as an error result: `err_cnt` = 1, and capture holds that word.
- **Reset mid-stream:** assert `rst` while locked with errors pending. All outputs are 0 immediately, and the first post-reset word produces no `err`.
